// File: rtl/bicubic_pkg.sv
// Shared widths, tap-select type and state encodings for the tap collector.
package bicubic_pkg;

    localparam int unsigned SAMPLE_W = 15;
    localparam int unsigned TAP_N    = 4;

    typedef logic [1:0]          tap_sel_t;
    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        StFill,
        StFull
    } state_e;

    typedef enum logic [1:0] {
        OpNone,
        OpWrite,
        OpShift,
        OpClear
    } bank_op_e;

    localparam tap_sel_t LAST_SLOT = 2'd3;

endpackage

// File: rtl/tap_shift4.sv
// 4x15-bit collect bank: slot write, shift-in at slot 3, or clear.
// taps_next exposes the post-update contents so a group can be loaded in the same cycle.
module tap_shift4
    import bicubic_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  bank_op_e                op,
    input  tap_sel_t                sel,
    input  sample_t                 din,
    output sample_t [TAP_N-1:0]     taps,
    output sample_t [TAP_N-1:0]     taps_next
);

    sample_t [TAP_N-1:0] taps_q;

    always_comb begin
        taps_next = taps_q;
        unique case (op)
            OpWrite: taps_next[sel] = din;
            OpShift: begin
                for (int i = 0; i < TAP_N - 1; i++) begin
                    taps_next[i] = taps_q[i+1];
                end
                taps_next[TAP_N-1] = din;
            end
            OpClear: taps_next = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_next;
        end
    end

    assign taps = taps_q;

endmodule

// File: rtl/tap_collector.sv
// Collects 15-bit samples into 4-tap groups with a valid/ready output handshake.
// Define TAP_COLLECTOR_OVERLAP_EN for a stride-1 sliding window instead of disjoint groups.
module tap_collector
    import bicubic_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [SAMPLE_W-1:0] in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [1:0]          mux_sel,
    output logic [SAMPLE_W-1:0] out_0,
    output logic [SAMPLE_W-1:0] out_1,
    output logic [SAMPLE_W-1:0] out_2,
    output logic [SAMPLE_W-1:0] out_3,
    output logic                out_valid,
    input  logic                out_ready
);

    state_e              state_q, state_d;
    tap_sel_t            sel_q, sel_d;
    sample_t [TAP_N-1:0] group_q;
    sample_t [TAP_N-1:0] bank_taps, bank_next;
    bank_op_e            bank_op;
    logic                accept, complete;

`ifdef TAP_COLLECTOR_OVERLAP_EN
    logic primed_q, primed_d;
`endif

    // Only a group-completing sample can stall; depends on registered state and out_ready only.
    assign in_ready = !((sel_q == LAST_SLOT) && (state_q == StFull) && !out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign complete = accept && (sel_q == LAST_SLOT);

    always_comb begin
        bank_op  = OpNone;
        sel_d    = sel_q;
        state_d  = state_q;
`ifdef TAP_COLLECTOR_OVERLAP_EN
        primed_d = primed_q;
`endif
        if (flush) begin
            bank_op  = OpClear;
            sel_d    = '0;
`ifdef TAP_COLLECTOR_OVERLAP_EN
            primed_d = 1'b0;
`endif
        end else if (accept) begin
`ifdef TAP_COLLECTOR_OVERLAP_EN
            bank_op = primed_q ? OpShift : OpWrite;
            sel_d   = (sel_q == LAST_SLOT) ? LAST_SLOT : tap_sel_t'(sel_q + 2'd1);
            if (complete) begin
                primed_d = 1'b1;
            end
`else
            bank_op = OpWrite;
            sel_d   = tap_sel_t'(sel_q + 2'd1);
`endif
        end

        if (complete) begin
            state_d = StFull;
        end else if ((state_q == StFull) && out_ready) begin
            state_d = StFill;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StFill;
            sel_q    <= '0;
            group_q  <= '0;
`ifdef TAP_COLLECTOR_OVERLAP_EN
            primed_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
`ifdef TAP_COLLECTOR_OVERLAP_EN
            primed_q <= primed_d;
`endif
            if (complete) begin
                group_q <= bank_next;
            end
        end
    end

    tap_shift4 u_bank (
        .clk       (clk),
        .rst       (rst),
        .op        (bank_op),
        .sel       (sel_q),
        .din       (in),
        .taps      (bank_taps),
        .taps_next (bank_next)
    );

    // The bank's current contents are only observed through taps_next.
    logic unused_taps;
    assign unused_taps = ^bank_taps;

    assign mux_sel   = sel_q;
    assign out_valid = (state_q == StFull);
    assign out_0     = group_q[0];
    assign out_1     = group_q[1];
    assign out_2     = group_q[2];
    assign out_3     = group_q[3];

endmodule

// File: tb/tb_tap_collector.sv
// Directed self-checking bench for tap_collector; overlap scenario runs when
// TAP_COLLECTOR_OVERLAP_EN is defined.
module tb_tap_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [14:0] in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  mux_sel;
    logic [14:0] out_0, out_1, out_2, out_3;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tap_collector dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mux_sel   (mux_sel),
        .out_0     (out_0),
        .out_1     (out_1),
        .out_2     (out_2),
        .out_3     (out_3),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [14:0] v);
        in       = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid);
        end
        n_checks++;
        if (mux_sel !== 2'd0) begin
            n_fail++; $display("FAIL reset_mux_sel: got %0d want 0", mux_sel);
        end
        n_checks++;
        if ({out_0, out_1, out_2, out_3} !== 60'd0) begin
            n_fail++; $display("FAIL reset_outs: got %h want 0", {out_0, out_1, out_2, out_3});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [14:0] v [4];
        v[0] = 15'h0011; v[1] = 15'h0022; v[2] = 15'h0033; v[3] = 15'h0044;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mux_sel !== 2'(i)) begin
                n_fail++; $display("FAIL basic_mux_sel%0d: got %0d want %0d", i, mux_sel, i);
            end
            push(v[i]);
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_out_valid: got %0b want 1", out_valid);
        end
        n_checks++;
        if ({out_0, out_1, out_2, out_3} !== {15'h0011, 15'h0022, 15'h0033, 15'h0044}) begin
            n_fail++; $display("FAIL basic_group: got %h %h %h %h want 0011 0022 0033 0044",
                               out_0, out_1, out_2, out_3);
        end
        n_checks++;
        if (mux_sel !== 2'd0) begin
            n_fail++; $display("FAIL basic_mux_wrap: got %0d want 0", mux_sel);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_consumed: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(15'h0100 + 15'(i));
        for (int i = 5; i <= 7; i++) begin
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL bp_ready_s%0d: got %0b want 1", i, in_ready);
            end
            push(15'h0100 + 15'(i));
        end
        in       = 15'h0108;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_stall%0d: got %0b want 0", c, in_ready);
            end
            n_checks++;
            if ({out_valid, out_0, out_1, out_2, out_3} !==
                {1'b1, 15'h0101, 15'h0102, 15'h0103, 15'h0104}) begin
                n_fail++; $display("FAIL bp_hold%0d: got %b %h %h %h %h want 1 0101..0104",
                                   c, out_valid, out_0, out_1, out_2, out_3);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got %0b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_0, out_1, out_2, out_3} !==
            {1'b1, 15'h0105, 15'h0106, 15'h0107, 15'h0108}) begin
            n_fail++; $display("FAIL bp_group2: got %b %h %h %h %h want 1 0105..0108",
                               out_valid, out_0, out_1, out_2, out_3);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in = 15'h0200 + 15'(i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_ready%0d: got %0b want 1", i, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== ((i % 4) == 3)) begin
                n_fail++; $display("FAIL b2b_valid%0d: got %0b want %0b",
                                   i, out_valid, (i % 4) == 3);
            end
            if ((i % 4) == 3) begin
                pulses++;
                n_checks++;
                if (out_3 !== 15'h0200 + 15'(i) || out_0 !== 15'h0200 + 15'(i - 3)) begin
                    n_fail++; $display("FAIL b2b_group%0d: got %h..%h want %h..%h",
                                       i / 4, out_0, out_3, 15'h0200 + 15'(i - 3),
                                       15'h0200 + 15'(i));
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (pulses != 3) begin
            n_fail++; $display("FAIL b2b_groups: got %0d want 3", pulses);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push(15'h0AAA);
        push(15'h0BBB);
        flush    = 1'b1;
        in       = 15'h0CCC;
        in_valid = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (mux_sel !== 2'd0) begin
            n_fail++; $display("FAIL flush_mux_sel: got %0d want 0", mux_sel);
        end
        push(15'h7FFF);
        push(15'h0000);
        push(15'h1234);
        push(15'h4321);
        n_checks++;
        if ({out_valid, out_0, out_1, out_2, out_3} !==
            {1'b1, 15'h7FFF, 15'h0000, 15'h1234, 15'h4321}) begin
            n_fail++; $display("FAIL flush_group: got %b %h %h %h %h want 1 7fff 0000 1234 4321",
                               out_valid, out_0, out_1, out_2, out_3);
        end
        push(15'h0555);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if ({out_valid, out_0, out_3, mux_sel} !== {1'b1, 15'h7FFF, 15'h4321, 2'd0}) begin
            n_fail++; $display("FAIL flush_keeps_held: got %b %h %h sel %0d want 1 7fff 4321 sel 0",
                               out_valid, out_0, out_3, mux_sel);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        push(15'h0301);
        push(15'h0302);
        push(15'h0303);
        rst = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, mux_sel, out_0, out_1, out_2, out_3} !== 63'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %b %0d %h %h %h %h want all 0",
                               out_valid, mux_sel, out_0, out_1, out_2, out_3);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready);
        end
        for (int i = 0; i < 4; i++) push(15'h0400 + 15'(i));
        n_checks++;
        if ({out_valid, out_0, out_1, out_2, out_3} !==
            {1'b1, 15'h0400, 15'h0401, 15'h0402, 15'h0403}) begin
            n_fail++; $display("FAIL rstmid_regroup: got %b %h %h %h %h want 1 0400..0403",
                               out_valid, out_0, out_1, out_2, out_3);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_overlap();
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL ovl_ready%0d: got %0b want 1", i, in_ready);
            end
            push(15'(i));
            n_checks++;
            if (out_valid !== (i >= 4)) begin
                n_fail++; $display("FAIL ovl_valid%0d: got %0b want %0b", i, out_valid, i >= 4);
            end
            if (i >= 4) begin
                n_checks++;
                if ({mux_sel, out_0, out_1, out_2, out_3} !==
                    {2'd3, 15'(i - 3), 15'(i - 2), 15'(i - 1), 15'(i)}) begin
                    n_fail++; $display("FAIL ovl_group%0d: got sel %0d %h %h %h %h want sel 3 %h..%h",
                                       i, mux_sel, out_0, out_1, out_2, out_3, i - 3, i);
                end
            end
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovl_drain: got %0b want 0", out_valid);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push(15'h0007);
        push(15'h0008);
        push(15'h0009);
        n_checks++;
        if ({out_valid, mux_sel} !== {1'b0, 2'd3}) begin
            n_fail++; $display("FAIL ovl_unprimed: got %b sel %0d want 0 sel 3", out_valid, mux_sel);
        end
        push(15'h000A);
        n_checks++;
        if ({out_valid, out_0, out_3} !== {1'b1, 15'h0007, 15'h000A}) begin
            n_fail++; $display("FAIL ovl_reprime: got %b %h %h want 1 0007 000a",
                               out_valid, out_0, out_3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef TAP_COLLECTOR_OVERLAP_EN
        test_overlap();
`else
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
